// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Resolves BITS_PER_CYCLE quotient bits per clock and holds the result until it is consumed.
module iter_divider #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_zero;
  logic             w_ovf;
  logic             w_special;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_last;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_zero    = (in_divisor == '0);
  assign w_ovf     = in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (in_divisor == '1);
  assign w_special = w_zero || w_ovf;
  assign w_a_neg   = in_signed & in_dividend[WIDTH-1];
  assign w_b_neg   = in_signed & in_divisor[WIDTH-1];
  assign w_a_mag   = w_a_neg ? (~in_dividend + 1'b1) : in_dividend;
  assign w_b_mag   = w_b_neg ? (~in_divisor + 1'b1) : in_divisor;
  assign w_last    = (r_cnt == CW'(1));

  // Unrolled restoring steps; the dividend shifts out of r_quo as quotient bits shift in.
  logic [WIDTH-1:0] w_rem_stg [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] w_quo_stg [BITS_PER_CYCLE+1];

  assign w_rem_stg[0] = r_rem;
  assign w_quo_stg[0] = r_quo;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [WIDTH:0] w_sh;
      logic           w_ge;
      assign w_sh = {w_rem_stg[gi], w_quo_stg[gi][WIDTH-1]};
      assign w_ge = (w_sh >= {1'b0, r_dvs});
      assign w_rem_stg[gi+1] = WIDTH'(w_ge ? (w_sh - {1'b0, r_dvs}) : w_sh);
      assign w_quo_stg[gi+1] = {w_quo_stg[gi][WIDTH-2:0], w_ge};
    end
  endgenerate

  assign w_q_fin = r_neg_q ? (~w_quo_stg[BITS_PER_CYCLE] + 1'b1) : w_quo_stg[BITS_PER_CYCLE];
  assign w_r_fin = r_neg_r ? (~w_rem_stg[BITS_PER_CYCLE] + 1'b1) : w_rem_stg[BITS_PER_CYCLE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_special ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_special) begin
              // Zero divisor takes precedence; the two special cases are mutually exclusive anyway.
              r_quotient  <= w_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
              r_remainder <= w_zero ? in_dividend : '0;
              r_dbz       <= w_zero;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= CW'(N);
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_stg[BITS_PER_CYCLE];
          r_quo <= w_quo_stg[BITS_PER_CYCLE];
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quotient  <= w_q_fin;
            r_remainder <= w_r_fin;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_quotient    = r_quotient;
  assign out_remainder   = r_remainder;
  assign out_div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: one instance per BITS_PER_CYCLE (1 and 4),
// directed corner cases, backpressure, mid-run reset and random operands against a plain-arithmetic model.
module tb_iter_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid   [2];
  logic         in_ready   [2];
  logic         in_signed  [2];
  logic [W-1:0] dividend   [2];
  logic [W-1:0] divisor    [2];
  logic         out_valid  [2];
  logic         out_ready  [2];
  logic [W-1:0] quo        [2];
  logic [W-1:0] rem        [2];
  logic         dbz        [2];

  int n_tests = 0;
  int n_fail  = 0;

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_signed(in_signed[0]),
    .in_dividend(dividend[0]), .in_divisor(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_quotient(quo[0]), .out_remainder(rem[0]), .out_div_by_zero(dbz[0])
  );

  iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_signed(in_signed[1]),
    .in_dividend(dividend[1]), .in_divisor(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_quotient(quo[1]), .out_remainder(rem[1]), .out_div_by_zero(dbz[1])
  );

  function automatic int n_iter(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V division rules using the simulator's own signed/unsigned arithmetic.
  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output logic sp);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    sp = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; sp = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = '0; sp = 1'b1;
    end else if (sgn) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Presents a request at a negedge; returns at the first negedge after the accept edge.
  task automatic start(input int k, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    while (!in_ready[k] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("in_ready_d%0d", k), W'(in_ready[k]), W'(1));
    in_valid[k]  = 1'b1;
    in_signed[k] = sgn;
    dividend[k]  = a;
    divisor[k]   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid[k]  = 1'b0;
    in_signed[k] = 1'($urandom);
    dividend[k]  = $urandom;
    divisor[k]   = $urandom;
  endtask

  // Waits for the result (out_ready must be 1), checks latency, values and the handshake.
  task automatic finish(input int k, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic ez, sp;
    int edges;
    ref_div(sgn, a, b, eq, er, ez, sp);
    edges = 0;
    while (!out_valid[k] && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    // Clock edges after the accept edge until out_valid is seen: 0 for special cases, N otherwise.
    chk($sformatf("lat_d%0d", k), W'(edges), W'(sp ? 0 : n_iter(k)));
    chk($sformatf("quo_d%0d", k), quo[k], eq);
    chk($sformatf("rem_d%0d", k), rem[k], er);
    chk($sformatf("dbz_d%0d", k), W'(dbz[k]), W'(ez));
    $display("[TB] dut%0d %s %h / %h -> q=%h r=%h z=%0b lat=%0d", k, sgn ? "s" : "u",
             a, b, quo[k], rem[k], dbz[k], edges);
    @(negedge clk);
    chk($sformatf("valid_drop_d%0d", k), W'(out_valid[k]), W'(0));
    chk($sformatf("ready_back_d%0d", k), W'(in_ready[k]), W'(1));
  endtask

  task automatic op(input int k, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    out_ready[k] = 1'b1;
    start(k, sgn, a, b);
    finish(k, sgn, a, b);
  endtask

  task automatic backpressure(input int k);
    logic [W-1:0] a, b, c, d, eq, er;
    logic ez, sp;
    int edges;
    a = $urandom; b = W'($urandom_range(1, 1000));
    c = $urandom; d = W'($urandom_range(1, 1000));
    ref_div(1'b0, a, b, eq, er, ez, sp);
    out_ready[k] = 1'b0;
    start(k, 1'b0, a, b);
    edges = 0;
    while (!out_valid[k] && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    chk($sformatf("bp_lat_d%0d", k), W'(edges), W'(n_iter(k)));
    in_valid[k] = 1'b1; in_signed[k] = 1'b0; dividend[k] = c; divisor[k] = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_quo_d%0d", k), quo[k], eq);
      chk($sformatf("bp_rem_d%0d", k), rem[k], er);
      chk($sformatf("bp_valid_d%0d", k), W'(out_valid[k]), W'(1));
      chk($sformatf("bp_ready_d%0d", k), W'(in_ready[k]), W'(0));
    end
    $display("[TB] dut%0d bp held %h / %h -> q=%h r=%h", k, a, b, quo[k], rem[k]);
    out_ready[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("bp_release_valid_d%0d", k), W'(out_valid[k]), W'(0));
    chk($sformatf("bp_release_ready_d%0d", k), W'(in_ready[k]), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    dividend[k] = $urandom;
    divisor[k]  = $urandom;
    finish(k, 1'b0, c, d);
  endtask

  task automatic reset_mid_run(input int k);
    int seen;
    out_ready[k] = 1'b1;
    start(k, 1'b0, $urandom, W'($urandom_range(1, 50000)));
    repeat ((k == 0) ? 10 : 5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk($sformatf("rst_valid_d%0d", k), W'(out_valid[k]), W'(0));
    chk($sformatf("rst_ready_d%0d", k), W'(in_ready[k]), W'(1));
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(out_valid[k]);
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      seen += int'(out_valid[k]);
    end
    chk($sformatf("rst_no_result_d%0d", k), W'(seen), W'(0));
    $display("[TB] dut%0d reset mid-run, result discarded", k);
    op(k, 1'b0, 32'd1000, 32'd10);
  endtask

  task automatic rand_op(input int k);
    logic sgn;
    logic [W-1:0] a, b;
    int sel;
    sgn = 1'($urandom);
    a   = $urandom;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: b = '0;
      1: b = W'($urandom_range(1, 15));
      2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      3: b = -W'($urandom_range(1, 15));
      default: b = $urandom >> $urandom_range(0, 31);
    endcase
    op(k, sgn, a, b);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_signed[k] = 1'b0;
      dividend[k] = '0;   divisor[k] = '0;
      out_ready[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_valid_d%0d", k), W'(out_valid[k]), W'(0));
      chk($sformatf("reset_ready_d%0d", k), W'(in_ready[k]), W'(1));
      chk($sformatf("reset_quo_d%0d", k), quo[k], '0);
      chk($sformatf("reset_rem_d%0d", k), rem[k], '0);
      chk($sformatf("reset_dbz_d%0d", k), W'(dbz[k]), W'(0));
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      op(k, 1'b0, 32'd100, 32'd7);
      op(k, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
      op(k, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      op(k, 1'b0, 32'd5, 32'd0);
      op(k, 1'b1, 32'd5, 32'd0);
      op(k, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      op(k, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      op(k, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);
      backpressure(k);
      reset_mid_run(k);
      for (int i = 0; i < 30; i++) begin
        rand_op(k);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle 32-bit integer divider for the datapath. It is the inverse-arithmetic companion to the adder, built on repeated subtract-and-compare.
- Accepts one dividend/divisor pair over a valid/ready handshake. Iterates BITS_PER_CYCLE quotient bits per clock, then holds the quotient and remainder until the consumer takes them.
- Implements RISC-V DIV/DIVU/REM/REMU semantics, including the divide-by-zero and signed-overflow rules.

Parameters:
- WIDTH, 32: operand and result width.
- BITS_PER_CYCLE, 1: quotient bits resolved per clock. Must divide WIDTH evenly; legal values are 1, 2, 4 and 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_dividend  input  WIDTH  dividend.
- in_divisor  input  WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_quotient  output  WIDTH  quotient.
- out_remainder  output  WIDTH  remainder.
- out_div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid=0, out_quotient=0, out_remainder=0, out_div_by_zero=0.
  - Iteration counter and working registers are cleared.
  - in_ready=1 while reset is held and after it is released.
- Reset asserted mid-operation aborts the operation. The result is discarded and never presented.
- States are IDLE, RUN and DONE. in_ready is 1 only in IDLE, so there are no overlapping operations.
- IDLE:
  - A request is accepted on an edge where in_valid & in_ready.
  - Operands and in_signed are captured on that edge. Later changes on the input ports have no effect.
  - If divisor==0, or the request is signed with dividend == most-negative and divisor == all-ones, the next state is DONE with the special result. Results are visible 1 cycle after acceptance.
  - Otherwise the next state is RUN.
    - In signed mode, operands are converted to magnitudes and the quotient and remainder signs are recorded.
    - The counter is loaded with N = WIDTH/BITS_PER_CYCLE.
- RUN:
  - Each edge performs BITS_PER_CYCLE restoring steps, MSB-first. For each step:
    - Shift the partial remainder left, bringing in the next dividend bit.
    - If the remainder is >= the divisor magnitude, subtract and set the quotient bit to 1; otherwise set it to 0.
  - The partial remainder is WIDTH+1 bits wide so the compare cannot overflow.
  - The counter decrements each edge. On the edge where it reaches 0, the next state is DONE.
  - Sign correction is applied on that edge:
    - The quotient is negated if the operand signs differ.
    - The remainder is negated if the dividend was negative.
  - Normal results are therefore visible exactly N cycles after acceptance: 32 cycles for BITS_PER_CYCLE=1, 8 cycles for 4.
- DONE:
  - out_valid=1. All out_* values stay stable until out_valid & out_ready.
  - On that edge the next state is IDLE and out_valid goes to 0. in_ready=1 in the following cycle.
  - out_quotient, out_remainder and out_div_by_zero keep their last values while out_valid=0. Consumers must ignore them.
- Special results:
  - Divide by zero (both modes): quotient = all-ones, remainder = dividend, out_div_by_zero=1.
  - Signed overflow: quotient = most-negative, remainder = 0, out_div_by_zero=0.
- Rounding: the quotient truncates toward zero. The remainder takes the sign of the dividend, so dividend = quotient*divisor + remainder always holds (mod 2^WIDTH).
- A simultaneous in_valid in RUN or DONE is ignored. It must be held by the producer until in_ready.

Test Plan:
- Unsigned 100/7, BITS_PER_CYCLE=1, out_ready=1 -> quotient=14, remainder=2, out_valid asserted 32 cycles after the accept edge for exactly 1 cycle.
- Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Unsigned 0xFFFFFFFF / 0x00000001 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero, 5/0 in each mode -> quotient=0xFFFFFFFF, remainder=5, out_div_by_zero=1, out_valid 1 cycle after accept.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, out_div_by_zero=0, 1-cycle latency. The same operands unsigned -> quotient=0, remainder=0x80000000 after 32 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs unchanged, in_ready=0, new in_valid ignored. Raise out_ready -> handshake, then in_ready=1 next cycle and the pending request is accepted.
- Reset mid-RUN (assert rst_n=0 10 cycles after accept) -> out_valid=0 and in_ready=1 immediately, no result emitted. After release, 1000/10 -> quotient=100, remainder=0. Repeat the suite with BITS_PER_CYCLE=4, checking 8-cycle latency.
